// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - button sample/debounce signal bundle
interface button_debouncer_if;
  logic       clk_1s;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  modport master (
    output clk_1s,
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  clk_1s,
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - four-button sampled debouncer with press/release pulses
// Define AUTOREPEAT_EN to build the per-button auto-repeat press generator.
module button_debouncer #(
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 25
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 15 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
    $error("button_debouncer: parameter out of range");
  end

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic       clk_1s_s1, clk_1s_s2, clk_1s_q;
  logic [3:0] btn_s1, btn_s2;
  logic       sample_stb;
  logic [3:0] level_vec, press_vec, release_vec;

  // Two-flop synchronizers for the slow tick and the raw buttons, plus tick edge register
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_1s_s1 <= 1'b0;
      clk_1s_s2 <= 1'b0;
      clk_1s_q  <= 1'b0;
      btn_s1    <= 4'b0;
      btn_s2    <= 4'b0;
    end else begin
      clk_1s_s1 <= bus.clk_1s;
      clk_1s_s2 <= clk_1s_s1;
      clk_1s_q  <= clk_1s_s2;
      btn_s1    <= bus.btn_in;
      btn_s2    <= btn_s1;
    end
  end

  // One-cycle strobe on each rising edge of the synchronized tick; masked in reset cycles
  assign sample_stb = clk_1s_s2 & ~clk_1s_q & ~reset;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept_press, accept_release, rep_pulse;
    logic       level_q, press_q, release_q;

    // Debounce FSM: advances only on strobes, counting consecutive equal samples
    always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      if (sample_stb) begin
        case (state_q)
          IDLE: begin
            if (btn_s2[i]) begin
              state_d = PRESS_WAIT;
              cnt_d   = 4'd1;
            end
          end
          PRESS_WAIT: begin
            if (btn_s2[i]) begin
              if (cnt_q + 4'd1 == STABLE_CNT) begin
                state_d      = HELD;
                cnt_d        = 4'd0;
                accept_press = 1'b1;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end
          end
          HELD: begin
            if (!btn_s2[i]) begin
              state_d = RELEASE_WAIT;
              cnt_d   = 4'd1;
            end
          end
          RELEASE_WAIT: begin
            if (!btn_s2[i]) begin
              if (cnt_q + 4'd1 == STABLE_CNT) begin
                state_d        = IDLE;
                cnt_d          = 4'd0;
                accept_release = 1'b1;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              state_d = HELD;
              cnt_d   = 4'd0;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end

`ifdef AUTOREPEAT_EN
    localparam logic [7:0] REP_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE  = 8'(REPEAT_RATE);

    logic [7:0] rep_q, rep_d;
    logic       rep_phase_q, rep_phase_d;

    // Repeat counter: first pulse after REP_DELAY held strobes, then one every REP_RATE;
    // frozen while waiting out a release, cleared whenever HELD is (re)entered
    always_comb begin
      rep_d       = rep_q;
      rep_phase_d = rep_phase_q;
      rep_pulse   = 1'b0;
      if (sample_stb) begin
        if (state_q == HELD && btn_s2[i]) begin
          rep_d = rep_q + 8'd1;
          if (!rep_phase_q && rep_d == REP_DELAY) begin
            rep_pulse   = 1'b1;
            rep_phase_d = 1'b1;
            rep_d       = 8'd0;
          end else if (rep_phase_q && rep_d == REP_RATE) begin
            rep_pulse = 1'b1;
            rep_d     = 8'd0;
          end
        end
        if (state_d == HELD && state_q != HELD) begin
          rep_d       = 8'd0;
          rep_phase_d = 1'b0;
        end
      end
    end

    // Repeat counter state
    always_ff @(posedge clk) begin
      if (reset) begin
        rep_q       <= 8'd0;
        rep_phase_q <= 1'b0;
      end else begin
        rep_q       <= rep_d;
        rep_phase_q <= rep_phase_d;
      end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    // FSM state plus registered level and single-cycle pulses
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        cnt_q     <= 4'd0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= (state_d == HELD) || (state_d == RELEASE_WAIT);
        press_q   <= accept_press | rep_pulse;
        release_q <= accept_release;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  button_debouncer_if bus ();

  button_debouncer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  // Monitor: every cycle showing a pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!reset && ((bus.btn_press | bus.btn_release) != 4'b0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse press=%b release=%b level=%b",
                 bus.btn_press, bus.btn_release, bus.btn_level);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.btn_press !== mon_e.press || bus.btn_release !== mon_e.rel ||
            bus.btn_level !== mon_e.level) begin
          bad++;
          $display("FAIL pulse_event got press=%b release=%b level=%b want press=%b release=%b level=%b",
                   bus.btn_press, bus.btn_release, bus.btn_level,
                   mon_e.press, mon_e.rel, mon_e.level);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  // One sample: set buttons while the tick is low, then raise the tick
  task automatic sample(input logic [3:0] b, input logic [3:0] ep,
                        input logic [3:0] er, input logic [3:0] el);
    ev_t e;
    if ((ep | er) != 4'b0) begin
      e.press = ep;
      e.rel   = er;
      e.level = el;
      exp_q.push_back(e);
    end
    @(negedge clk) bus.btn_in = b;
    repeat (3) @(negedge clk);
    bus.clk_1s = 1'b1;
    repeat (4) @(negedge clk);
    bus.clk_1s = 1'b0;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int k = 1; k <= n; k++)
      sample(b, (k == n) ? b : 4'b0, 4'b0, b);
  endtask

  task automatic release_all(input logic [3:0] was);
    for (int k = 1; k <= 4; k++)
      sample(4'b0, 4'b0, (k == 4) ? was : 4'b0, 4'b0);
  endtask

  logic [3:0] pat7 [7];
  logic [3:0] ep;

  initial begin
    bus.btn_in = 4'b0;
    bus.clk_1s = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_level",   bus.btn_level,   4'b0);
    check("reset_press",   bus.btn_press,   4'b0);
    check("reset_release", bus.btn_release, 4'b0);

    // Steady single button: press after 4th sample
    hold(4'b0001, 4);
    @(negedge clk);
    check("level_after_press0", bus.btn_level, 4'b0001);
    release_all(4'b0001);

    // Bouncy button 1: 1,1,0,1,1,1,1 -> single press after 7th sample
    pat7 = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    for (int k = 0; k < 7; k++)
      sample(pat7[k], (k == 6) ? 4'b0010 : 4'b0, 4'b0, 4'b0010);
    release_all(4'b0010);

    // Glitch between strobes is ignored, both mid-count and in idle
    sample(4'b0001, 4'b0, 4'b0, 4'b0);
    sample(4'b0001, 4'b0, 4'b0, 4'b0);
    @(negedge clk) bus.btn_in = 4'b0000;
    repeat (2) @(negedge clk);
    bus.btn_in = 4'b0001;
    repeat (6) @(negedge clk);
    sample(4'b0001, 4'b0, 4'b0, 4'b0);
    sample(4'b0001, 4'b0001, 4'b0, 4'b0001);
    release_all(4'b0001);
    @(negedge clk) bus.btn_in = 4'b0100;
    repeat (2) @(negedge clk);
    bus.btn_in = 4'b0000;
    repeat (8) @(negedge clk);

    // Two buttons together
    hold(4'b1010, 4);
    release_all(4'b1010);

    // Reset while held: level drops, no release, re-accepted after 4 fresh samples
    hold(4'b0100, 4);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("level_after_reset", bus.btn_level, 4'b0);
    hold(4'b0100, 4);
    release_all(4'b0100);

    // Long hold on button 3
    for (int k = 1; k <= 150; k++) begin
      ep = (k == 4) ? 4'b1000 : 4'b0;
`ifdef AUTOREPEAT_EN
      if (k == 104 || k == 129) ep = 4'b1000;
`endif
      sample(4'b1000, ep, 4'b0, 4'b1000);
    end
    release_all(4'b1000);

    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses outstanding=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
